id_ex_stage: RTL

ID/EX pipeline stage of the RV64I+Zba core: registers decoded operands and control, applies operand forwarding from MEM and WB, and drives `SrcA`/`SrcB`/`ALUControl` straight into the execute-stage ALU. It also owns load-use hazard detection and branch/jump flush, returning stall/flush controls to fetch and decode. Sits between the decode stage and the ALU; EX/MEM consumes its registered control outputs.

---
 rtl/core_pkg.sv | 64 ++++++
 rtl/forward_unit.sv | 36 +++
 rtl/id_ex_stage.sv | 122 ++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared types for the RV64I+Zba execute front end: ALU opcodes, result-source
// encodings and the packed ID/EX pipeline register.
package core_pkg;

    localparam int XLEN = 64;

    typedef enum logic [4:0] {
        ALU_ADD       = 5'b00000,
        ALU_SUB       = 5'b00001,
        ALU_AND       = 5'b00010,
        ALU_OR        = 5'b00011,
        ALU_XOR       = 5'b00100,
        ALU_SLT       = 5'b00101,
        ALU_SLTU      = 5'b00110,
        ALU_SLL       = 5'b00111,
        ALU_SRL       = 5'b01000,
        ALU_SRA       = 5'b01001,
        ALU_ADDW      = 5'b01010,
        ALU_SUBW      = 5'b01011,
        ALU_SLLW      = 5'b01100,
        ALU_SRLW      = 5'b01101,
        ALU_SRAW      = 5'b01110,
        ALU_SH1ADD    = 5'b10000,
        ALU_SH2ADD    = 5'b10001,
        ALU_SH3ADD    = 5'b10010,
        ALU_ADD_UW    = 5'b10011,
        ALU_SH1ADD_UW = 5'b10100,
        ALU_SH2ADD_UW = 5'b10101,
        ALU_SH3ADD_UW = 5'b10110
    } alu_op_e;

    typedef enum logic [1:0] {
        RESULT_ALU  = 2'b00,
        RESULT_LOAD = 2'b01,
        RESULT_PC4  = 2'b10
    } result_src_e;

    typedef struct packed {
        logic              reg_write;
        logic              mem_write;
        logic              branch;
        logic              jump;
        result_src_e       result_src;
        alu_op_e           alu_control;
        logic              alu_src;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
        logic [XLEN-1:0]   rd1;
        logic [XLEN-1:0]   rd2;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   imm_ext;
    } id_ex_t;

    localparam id_ex_t ID_EX_BUBBLE = '0;

    // x0 is hardwired to zero, so a write to it must never be forwarded.
    function automatic logic forward_hit(input logic [4:0] rs,
                                         input logic [4:0] rd,
                                         input logic       reg_write);
        return (rs != 5'd0) && reg_write && (rd == rs);
    endfunction

endpackage

// File: rtl/forward_unit.sv
// Operand bypass selection for the execute stage: MEM result beats WB result,
// which beats the value read from the register file in decode.
module forward_unit
    import core_pkg::*;
(
    input  logic [4:0]      rs1_e,
    input  logic [4:0]      rs2_e,
    input  logic [XLEN-1:0] rd1_e,
    input  logic [XLEN-1:0] rd2_e,
    input  logic [4:0]      rd_m,
    input  logic            reg_write_m,
    input  logic [XLEN-1:0] alu_result_m,
    input  logic [4:0]      rd_w,
    input  logic            reg_write_w,
    input  logic [XLEN-1:0] result_w,
    output logic [XLEN-1:0] fwd_rs1,
    output logic [XLEN-1:0] fwd_rs2
);

    always_comb begin
        fwd_rs1 = rd1_e;
        if (forward_hit(rs1_e, rd_m, reg_write_m)) begin
            fwd_rs1 = alu_result_m;
        end else if (forward_hit(rs1_e, rd_w, reg_write_w)) begin
            fwd_rs1 = result_w;
        end

        fwd_rs2 = rd2_e;
        if (forward_hit(rs2_e, rd_m, reg_write_m)) begin
            fwd_rs2 = alu_result_m;
        end else if (forward_hit(rs2_e, rd_w, reg_write_w)) begin
            fwd_rs2 = result_w;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding into the ALU and
// load-use / taken-branch hazard control back to fetch and decode.
module id_ex_stage
    import core_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] RD1D,
    input  logic [XLEN-1:0] RD2D,
    input  logic [XLEN-1:0] ImmExtD,
    input  logic [XLEN-1:0] PCD,
    input  logic [4:0]      Rs1D,
    input  logic [4:0]      Rs2D,
    input  logic [4:0]      RdD,
    input  logic [4:0]      ALUControlD,
    input  logic            ALUSrcD,
    input  logic            RegWriteD,
    input  logic            MemWriteD,
    input  logic            BranchD,
    input  logic            JumpD,
    input  logic [1:0]      ResultSrcD,
    input  logic [4:0]      RdM,
    input  logic            RegWriteM,
    input  logic [XLEN-1:0] ALUResultM,
    input  logic [4:0]      RdW,
    input  logic            RegWriteW,
    input  logic [XLEN-1:0] ResultW,
    input  logic            PCSrcE,
    output logic [XLEN-1:0] SrcA,
    output logic [XLEN-1:0] SrcB,
    output logic [4:0]      ALUControl,
    output logic [XLEN-1:0] WriteDataE,
    output logic [XLEN-1:0] PCE,
    output logic [XLEN-1:0] ImmExtE,
    output logic [4:0]      RdE,
    output logic            RegWriteE,
    output logic            MemWriteE,
    output logic            BranchE,
    output logic            JumpE,
    output logic [1:0]      ResultSrcE,
    output logic            StallF,
    output logic            StallD,
    output logic            FlushD
);

    id_ex_t          id_ex_d;
    id_ex_t          id_ex_q;
    logic            lw_stall;
    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;

    // Hazard detection looks only at registered state and decode indices,
    // so it never depends on the forwarded operands.
    always_comb begin
        lw_stall = (id_ex_q.result_src == RESULT_LOAD) &&
                   (id_ex_q.rd != 5'd0) &&
                   ((id_ex_q.rd == Rs1D) || (id_ex_q.rd == Rs2D));
    end

    always_comb begin
        id_ex_d = ID_EX_BUBBLE;
        if (!(lw_stall || PCSrcE)) begin
            id_ex_d.reg_write   = RegWriteD;
            id_ex_d.mem_write   = MemWriteD;
            id_ex_d.branch      = BranchD;
            id_ex_d.jump        = JumpD;
            id_ex_d.result_src  = result_src_e'(ResultSrcD);
            id_ex_d.alu_control = alu_op_e'(ALUControlD);
            id_ex_d.alu_src     = ALUSrcD;
            id_ex_d.rs1         = Rs1D;
            id_ex_d.rs2         = Rs2D;
            id_ex_d.rd          = RdD;
            id_ex_d.rd1         = RD1D;
            id_ex_d.rd2         = RD2D;
            id_ex_d.pc          = PCD;
            id_ex_d.imm_ext     = ImmExtD;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            id_ex_q <= ID_EX_BUBBLE;
        end else begin
            id_ex_q <= id_ex_d;
        end
    end

    forward_unit u_forward_unit (
        .rs1_e        (id_ex_q.rs1),
        .rs2_e        (id_ex_q.rs2),
        .rd1_e        (id_ex_q.rd1),
        .rd2_e        (id_ex_q.rd2),
        .rd_m         (RdM),
        .reg_write_m  (RegWriteM),
        .alu_result_m (ALUResultM),
        .rd_w         (RdW),
        .reg_write_w  (RegWriteW),
        .result_w     (ResultW),
        .fwd_rs1      (fwd_rs1),
        .fwd_rs2      (fwd_rs2)
    );

    assign SrcA       = fwd_rs1;
    assign SrcB       = id_ex_q.alu_src ? id_ex_q.imm_ext : fwd_rs2;
    assign WriteDataE = fwd_rs2;
    assign ALUControl = id_ex_q.alu_control;
    assign PCE        = id_ex_q.pc;
    assign ImmExtE    = id_ex_q.imm_ext;
    assign RdE        = id_ex_q.rd;
    assign RegWriteE  = id_ex_q.reg_write;
    assign MemWriteE  = id_ex_q.mem_write;
    assign BranchE    = id_ex_q.branch;
    assign JumpE      = id_ex_q.jump;
    assign ResultSrcE = id_ex_q.result_src;

    // A flush alongside a load-use stall keeps the stall asserted; the flush
    // discards the held decode instruction anyway.
    assign StallF = lw_stall;
    assign StallD = lw_stall;
    assign FlushD = PCSrcE;

endmodule
